// File: rtl/tt_sweep_capture_pkg.sv
// tt_sweep_pkg
//   Shared definitions for the truth-table sweep/capture harness:
//   - sweep_state_t : sweep controller states
//   - SIG_POLY      : default signature feedback polynomial
//   - SIG_SEED      : default signature start value
//   - sig_step()    : one signature update for the default 16-bit width,
//                     usable from both RTL and testbench code
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam logic [15:0] SIG_POLY = 16'h1021;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // Feedback is the outgoing MSB xor the incoming response bit; the
  // polynomial is folded in only when that feedback bit is set.
  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic b);
    logic fb;
    fb = s[15] ^ b;
    return {s[14:0], 1'b0} ^ (fb ? SIG_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tt_sweep_capture_sig_lfsr.sv
// sig_lfsr
//   Response signature register. Loads SEED on 'load', otherwise folds one
//   response bit into the signature on every cycle 'step' is high.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset (signature returns to SEED)
//   load  in   reload SEED (takes priority over step)
//   step  in   fold 'din' into the signature this cycle
//   din   in   response bit
//   sig   out  current signature (SIG_W bits)
module sig_lfsr
  import tt_sweep_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_POLY,
  parameter logic [SIG_W-1:0] SEED  = SIG_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic             w_fb;

  assign w_fb = r_sig[SIG_W-1] ^ din;
  assign sig  = r_sig;

  // Galois-style shift: shift left, then xor in the polynomial whenever
  // the feedback bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= SEED;
    end else if (load) begin
      r_sig <= SEED;
    end else if (step) begin
      r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture
//   Sweeps every input minterm of a N_IN-input, 1-output combinational
//   netlist in ascending order, captures the full truth table, counts the
//   on-set and compresses the response into a signature.
// Optional feature (macro TT_COMPARE_EN): compares each captured bit with
//   parameter EXP_TT and reports 'mismatch' and the first failing minterm.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a sweep (honoured in IDLE or DONE only)
//   x_out      out  minterm driven to the netlist (x_out[0] -> x0)
//   y_in       in   netlist output y0
//   busy       out  high while driving or draining
//   done       out  high once the sweep has finished
//   tt         out  captured truth table, tt[i] = y for minterm i
//   ones_cnt   out  number of minterms with y = 1
//   sig        out  response signature
//   mismatch   out  (TT_COMPARE_EN) some capture differed from EXP_TT
//   first_fail out  (TT_COMPARE_EN) lowest minterm that differed
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int               N_IN  = 7,
  parameter int               LAT   = 0,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_POLY,
  parameter logic [SIG_W-1:0] SEED  = SIG_SEED
`ifdef TT_COMPARE_EN
  ,
  parameter logic [2**N_IN-1:0] EXP_TT = '0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      x_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        ones_cnt,
  output logic [SIG_W-1:0]     sig
`ifdef TT_COMPARE_EN
  ,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_fail
`endif
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  sweep_state_t        r_state;
  sweep_state_t        w_next;
  logic                r_start;
  logic                w_launch;
  logic [N_IN-1:0]     r_x;
  logic [2**N_IN-1:0]  r_tt;
  logic [N_IN:0]       r_ones;
  logic                w_capValid;
  logic [N_IN-1:0]     w_capIdx;
  logic                w_drainLast;

  assign x_out    = r_x;
  assign tt       = r_tt;
  assign ones_cnt = r_ones;

  // Start is registered, and only when the controller can accept it, so a
  // pulse that arrives while busy can never leak into a later cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
    end else begin
      r_start <= start & ((r_state == IDLE) | (r_state == DONE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status decode. w_launch marks the cycle a sweep begins
  // and is what clears all of the capture state.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_launch = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_start) begin
          w_next   = DRIVE;
          w_launch = 1'b1;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (r_x == LAST_IDX) begin
          w_next = (LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_drainLast) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (r_start) begin
          w_next   = DRIVE;
          w_launch = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Minterm counter; it doubles as the registered netlist input and parks
  // on the last minterm until the next sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
    end else if (w_launch) begin
      r_x <= '0;
    end else if ((r_state == DRIVE) && (r_x != LAST_IDX)) begin
      r_x <= r_x + 1'b1;
    end
  end

  // The capture point trails the driven minterm by the netlist latency.
  generate
    if (LAT == 0) begin : g_noLat
      assign w_capValid  = (r_state == DRIVE);
      assign w_capIdx    = r_x;
      assign w_drainLast = 1'b0;
    end else begin : g_lat
      localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

      logic [LAT-1:0]  r_dv;
      logic [N_IN-1:0] r_di [LAT];
      logic [CW-1:0]   r_drainCnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dv <= '0;
          for (int i = 0; i < LAT; i++) begin
            r_di[i] <= '0;
          end
        end else begin
          r_dv[0] <= (r_state == DRIVE);
          r_di[0] <= r_x;
          for (int i = 1; i < LAT; i++) begin
            r_dv[i] <= r_dv[i-1];
            r_di[i] <= r_di[i-1];
          end
        end
      end

      // Counts the DRAIN cycles so the last one lines up with the final
      // capture leaving the delay line.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_drainCnt <= '0;
        end else if (r_state != DRAIN) begin
          r_drainCnt <= '0;
        end else begin
          r_drainCnt <= r_drainCnt + 1'b1;
        end
      end

      assign w_capValid  = r_dv[LAT-1];
      assign w_capIdx    = r_di[LAT-1];
      assign w_drainLast = (r_drainCnt == CW'(LAT - 1));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_launch) begin
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_capValid) begin
      r_tt[w_capIdx] <= y_in;
      r_ones         <= r_ones + {{N_IN{1'b0}}, y_in};
    end
  end

  sig_lfsr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_sig (
    .clk  (clk),
    .rst  (rst),
    .load (w_launch),
    .step (w_capValid),
    .din  (y_in),
    .sig  (sig)
  );

`ifdef TT_COMPARE_EN
  logic            r_mis;
  logic [N_IN-1:0] r_firstFail;

  assign mismatch   = r_mis;
  assign first_fail = r_firstFail;

  // Captures arrive in ascending order, so the first miss is the lowest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis       <= 1'b0;
      r_firstFail <= '0;
    end else if (w_launch) begin
      r_mis       <= 1'b0;
      r_firstFail <= '0;
    end else if (w_capValid && (y_in != EXP_TT[w_capIdx])) begin
      if (!r_mis) begin
        r_firstFail <= w_capIdx;
      end
      r_mis <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture
//   Drives two harness instances (LAT=0 with a combinational response and
//   LAT=2 with a two-flop delayed response) from truth tables held in the
//   bench, and checks every cycle against a sweep-level model: outputs are
//   derived from the cycle count since start and the table being swept.
module tb_tt_sweep_capture;
  import tt_sweep_pkg::*;

  localparam logic [127:0] X0_PAT = {32{4'hA}};
  localparam logic [127:0] X6_PAT = {{64{1'b1}}, {64{1'b0}}};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [6:0]   x0o, x2o;
  logic         y0, y2;
  logic         busy0, done0, busy2, done2;
  logic [127:0] tt0, tt2;
  logic [7:0]   ones0, ones2;
  logic [15:0]  sig0, sig2;
`ifdef TT_COMPARE_EN
  logic         mis0, mis2;
  logic [6:0]   ff0, ff2;
`endif

  logic [127:0] tab0, tab2;
  logic         d1, d2;

  int           nChecks = 0;
  int           nFails  = 0;
  int           cyc     = 0;
  int           phase;
  int           startCyc;
  logic [127:0] expTt0, expTt2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response models: dut0 sees the table combinationally, dut2 through
  // two flops.
  assign y0 = tab0[x0o];
  always @(posedge clk) begin
    d1 <= tab2[x2o];
    d2 <= d1;
  end
  assign y2 = d2;

  tt_sweep_capture #(
    .N_IN (7),
    .LAT  (0)
`ifdef TT_COMPARE_EN
    , .EXP_TT (X0_PAT)
`endif
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_out    (x0o),
    .y_in     (y0),
    .busy     (busy0),
    .done     (done0),
    .tt       (tt0),
    .ones_cnt (ones0),
    .sig      (sig0)
`ifdef TT_COMPARE_EN
    , .mismatch   (mis0)
    , .first_fail (ff0)
`endif
  );

  tt_sweep_capture #(
    .N_IN (7),
    .LAT  (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_out    (x2o),
    .y_in     (y2),
    .busy     (busy2),
    .done     (done2),
    .tt       (tt2),
    .ones_cnt (ones2),
    .sig      (sig2)
`ifdef TT_COMPARE_EN
    , .mismatch   (mis2)
    , .first_fail (ff2)
`endif
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Signature of a whole table: seed, then one step per minterm, ascending.
  function automatic logic [15:0] modelSig(input logic [127:0] t);
    logic [15:0] s;
    s = SIG_SEED;
    for (int i = 0; i < 128; i++) s = sig_step(s, t[i]);
    return s;
  endfunction

  function automatic int popCount(input logic [127:0] t);
    int c;
    c = 0;
    for (int i = 0; i < 128; i++) c += int'(t[i]);
    return c;
  endfunction

  function automatic int firstDiff(input logic [127:0] a, input logic [127:0] b);
    for (int i = 0; i < 128; i++) if (a[i] != b[i]) return i;
    return 0;
  endfunction

  task automatic checkReset();
    checkOutput("rst x0", 128'(x0o), 128'(0));
    checkOutput("rst busy0", 128'(busy0), 128'(0));
    checkOutput("rst done0", 128'(done0), 128'(0));
    checkOutput("rst tt0", tt0, 128'(0));
    checkOutput("rst ones0", 128'(ones0), 128'(0));
    checkOutput("rst sig0", 128'(sig0), 128'(SIG_SEED));
    checkOutput("rst x2", 128'(x2o), 128'(0));
    checkOutput("rst busy2", 128'(busy2), 128'(0));
    checkOutput("rst done2", 128'(done2), 128'(0));
    checkOutput("rst tt2", tt2, 128'(0));
    checkOutput("rst ones2", 128'(ones2), 128'(0));
    checkOutput("rst sig2", 128'(sig2), 128'(SIG_SEED));
`ifdef TT_COMPARE_EN
    checkOutput("rst mis0", 128'(mis0), 128'(0));
    checkOutput("rst ff0", 128'(ff0), 128'(0));
    checkOutput("rst mis2", 128'(mis2), 128'(0));
    checkOutput("rst ff2", 128'(ff2), 128'(0));
`endif
  endtask

  // n counts edges since start was sampled: minterm n-1 is driven during
  // cycle n, busy spans 128+LAT cycles, done from cycle 129+LAT onward.
  task automatic checkDut(input string tag, input int lat, input int n,
                          input logic [6:0] x, input logic b, input logic d,
                          input logic [127:0] t, input logic [7:0] o,
                          input logic [15:0] s, input logic [127:0] eTt);
    int expX;
    expX = (n - 1 > 127) ? 127 : n - 1;
    checkOutput({tag, " busy"}, 128'(b), 128'(n <= 128 + lat));
    checkOutput({tag, " done"}, 128'(d), 128'(n >= 129 + lat));
    checkOutput({tag, " x_out"}, 128'(x), 128'(expX));
    if (n >= 129 + lat) begin
      checkOutput({tag, " tt"}, t, eTt);
      checkOutput({tag, " ones"}, 128'(o), 128'(popCount(eTt)));
      checkOutput({tag, " sig"}, 128'(s), 128'(modelSig(eTt)));
    end
  endtask

  always @(negedge clk) begin : cmp
    int n;
    if (phase == 0) begin
      checkReset();
    end else begin
      n = cyc - startCyc;
      if (n >= 1) begin
        checkDut("dut0", 0, n, x0o, busy0, done0, tt0, ones0, sig0, expTt0);
        checkDut("dut2", 2, n, x2o, busy2, done2, tt2, ones2, sig2, expTt2);
`ifdef TT_COMPARE_EN
        if (n >= 129) begin
          checkOutput("dut0 mismatch", 128'(mis0), 128'(expTt0 != X0_PAT));
          checkOutput("dut0 first_fail", 128'(ff0), 128'(firstDiff(expTt0, X0_PAT)));
        end
        if (n >= 131) begin
          checkOutput("dut2 mismatch", 128'(mis2), 128'(expTt2 != 128'(0)));
          checkOutput("dut2 first_fail", 128'(ff2), 128'(firstDiff(expTt2, 128'(0))));
        end
`endif
      end
    end
  end

  // Loads the response tables and pulses start for one edge; the model
  // expectations are snapshotted here so later table edits cannot leak in.
  task automatic applyStimulus(input logic [127:0] t0, input logic [127:0] t2);
    @(negedge clk);
    #1;
    tab0   = t0;
    tab2   = t2;
    expTt0 = t0;
    expTt2 = t2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    startCyc = cyc;
    phase    = 1;
  endtask

  task automatic runSweep(input logic [127:0] t0, input logic [127:0] t2,
                          input int midStart, input int midReset, input bit measure);
    int  n, b0, b2, da0, da2;
    bit  finished;
    b0 = 0; b2 = 0; da0 = -1; da2 = -1; finished = 0;
    applyStimulus(t0, t2);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n = cyc - startCyc;
      if (midReset >= 0 && int'(x0o) == midReset && busy0) begin
        #2 rst = 1'b1;
        #1 checkReset();
        phase = 0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      start = (int'(x0o) == midStart) && busy0;
      if (n >= 1) begin
        if (busy0) b0++;
        if (busy2) b2++;
        if (done0 && da0 < 0) da0 = n;
        if (done2 && da2 < 0) da2 = n;
        if (done0 && done2) begin
          finished = 1;
          break;
        end
      end
    end
    start = 1'b0;
    if (!finished) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL sweep timeout: done0=%0b done2=%0b, required both 1 within 400 cycles", done0, done2);
    end else if (measure) begin
      checkOutput("dut0 done latency", 128'(da0), 128'(129));
      checkOutput("dut0 busy cycles", 128'(b0), 128'(128));
      checkOutput("dut2 done latency", 128'(da2), 128'(131));
      checkOutput("dut2 busy cycles", 128'(b2), 128'(130));
    end
  endtask

  function automatic logic [127:0] randTable();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tab0  = '0;
    tab2  = '0;
    phase = 0;
    startCyc = 0;
    expTt0 = '0;
    expTt2 = '0;

    // Hand-worked signature steps that pin the shared step function.
    checkOutput("sig_step FFFF,0", 128'(sig_step(16'hFFFF, 1'b0)), 128'(16'hEFDF));
    checkOutput("sig_step 8000,1", 128'(sig_step(16'h8000, 1'b1)), 128'(16'h0000));
    checkOutput("sig_step 0000,1", 128'(sig_step(16'h0000, 1'b1)), 128'(16'h1021));
    checkOutput("sig_step 0001,0", 128'(sig_step(16'h0001, 1'b0)), 128'(16'h0002));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] sweep: y=x0 / y=x6, with ignored start at idx 40");
    runSweep(X0_PAT, X6_PAT, 40, -1, 1);
    checkOutput("x0 pattern tt", tt0, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    checkOutput("x0 pattern ones", 128'(ones0), 128'(64));
    checkOutput("x6 pattern tt", tt2, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
    checkOutput("x6 pattern ones", 128'(ones2), 128'(64));
`ifdef TT_COMPARE_EN
    checkOutput("x0 pattern mismatch", 128'(mis0), 128'(0));
`endif

    $display("[TB] sweep: restart from DONE with identical tables");
    runSweep(X0_PAT, X6_PAT, -1, -1, 1);

    $display("[TB] sweep: constant zero response");
    runSweep('0, '0, -1, -1, 1);
    checkOutput("zero tt", tt0, 128'(0));
    checkOutput("zero ones", 128'(ones0), 128'(0));

    for (int k = 0; k < 3; k++) begin
      $display("[TB] sweep: random tables %0d", k);
      runSweep(randTable(), randTable(), -1, -1, 1);
    end

    $display("[TB] sweep: reset at idx 50, then fresh sweep");
    runSweep(randTable(), randTable(), -1, 50, 0);
    repeat (2) @(negedge clk);
    runSweep(randTable(), randTable(), -1, -1, 1);

    $display("[TB] sweep: all-ones response");
    runSweep('1, '1, -1, -1, 1);
    checkOutput("ones count full", 128'(ones0), 128'(128));

`ifdef TT_COMPARE_EN
    $display("[TB] sweep: x0 pattern with minterm 5 inverted");
    runSweep(X0_PAT ^ (128'd1 << 5), X6_PAT, -1, -1, 1);
    checkOutput("cmp mismatch", 128'(mis0), 128'(1));
    checkOutput("cmp first_fail", 128'(ff0), 128'(5));
    checkOutput("cmp dut2 first_fail", 128'(ff2), 128'(64));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
